// File: rtl/camera_controller.sv
// Camera pose owner: per frame tick, steps yaw, rebuilds forward/right vectors and moves the origin.
// Optional: define CAMERA_BOUNDS_EN to clamp the origin to a +/-BOUND cube.
module camera_controller #(
  parameter int BITS   = 32,
  parameter int FRAC   = 16,
  parameter int FOCAL  = 150,
  parameter int SPEED  = 2,
  parameter int ORI_Z0 = 150,
  parameter int BOUND  = 1000
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   frame_tick_in,
  input  logic                   btn_fwd_in,
  input  logic                   btn_back_in,
  input  logic                   btn_left_in,
  input  logic                   btn_right_in,
  input  logic                   btn_yaw_l_in,
  input  logic                   btn_yaw_r_in,
  output logic signed [BITS-1:0] camera_ori_x,
  output logic signed [BITS-1:0] camera_ori_y,
  output logic signed [BITS-1:0] camera_ori_z,
  output logic signed [BITS-1:0] camera_u_x,
  output logic signed [BITS-1:0] camera_u_y,
  output logic signed [BITS-1:0] camera_u_z,
  output logic signed [BITS-1:0] camera_v_x,
  output logic signed [BITS-1:0] camera_v_y,
  output logic signed [BITS-1:0] camera_v_z,
  output logic signed [BITS-1:0] camera_forward_x,
  output logic signed [BITS-1:0] camera_forward_y,
  output logic signed [BITS-1:0] camera_forward_z,
  output logic [7:0]             yaw_out,
  output logic                   busy_out,
  output logic                   update_out
);

  localparam int W = BITS + 8;
  // The ROM is stored at 16 fractional bits and rescaled to FRAC.
  localparam int unsigned LutUp = (FRAC >= 16) ? FRAC - 16 : 0;
  localparam int unsigned LutDn = (FRAC >= 16) ? 0 : 16 - FRAC;

  localparam logic signed [BITS-1:0] OneFx   = BITS'(1) <<< FRAC;
  localparam logic signed [BITS-1:0] FocalB  = BITS'(FOCAL);
  localparam logic signed [BITS-1:0] OriZ0Fx = BITS'(ORI_Z0) <<< FRAC;
  localparam logic signed [BITS-1:0] FwdZ0Fx = -(FocalB <<< FRAC);
  localparam logic signed [BITS-1:0] MaxB    = {1'b0, {(BITS-1){1'b1}}};
  localparam logic signed [BITS-1:0] MinB    = {1'b1, {(BITS-1){1'b0}}};
  localparam logic signed [W-1:0]    MaxW    = W'(MaxB);
  localparam logic signed [W-1:0]    MinW    = W'(MinB);
  localparam logic signed [W-1:0]    SpeedW  = W'(SPEED);
`ifdef CAMERA_BOUNDS_EN
  localparam logic signed [W-1:0]    BoundW  = W'(BOUND) <<< FRAC;
`endif

  if (FRAC < 1 || FRAC > BITS - 10 || BOUND < 1) begin : g_bad_params
    $error("camera_controller: unsupported FRAC/BOUND");
  end

  // round(sin(k*2pi/256) * 2^16), k = 0..64
  localparam logic [16:0] QuarterLut [0:64] = '{
    17'd0,     17'd1608,  17'd3216,  17'd4821,  17'd6424,  17'd8022,  17'd9616,  17'd11204,
    17'd12785, 17'd14359, 17'd15924, 17'd17479, 17'd19024, 17'd20557, 17'd22078, 17'd23586,
    17'd25080, 17'd26558, 17'd28020, 17'd29466, 17'd30893, 17'd32303, 17'd33692, 17'd35062,
    17'd36410, 17'd37736, 17'd39040, 17'd40320, 17'd41576, 17'd42806, 17'd44011, 17'd45190,
    17'd46341, 17'd47464, 17'd48559, 17'd49624, 17'd50660, 17'd51665, 17'd52639, 17'd53581,
    17'd54491, 17'd55368, 17'd56212, 17'd57022, 17'd57798, 17'd58538, 17'd59244, 17'd59914,
    17'd60547, 17'd61145, 17'd61705, 17'd62228, 17'd62714, 17'd63162, 17'd63572, 17'd63944,
    17'd64277, 17'd64571, 17'd64827, 17'd65043, 17'd65220, 17'd65358, 17'd65457, 17'd65516,
    17'd65536
  };

  typedef enum logic [2:0] {StIdle, StYaw, StTrig, StScale, StCommit} state_e;

  state_e                 state_q;
  logic                   fwd_q, back_q, left_q, right_q, yaw_l_q, yaw_r_q;
  logic [7:0]             yaw_q;
  logic signed [BITS-1:0] sin_q, cos_q;
  logic signed [BITS-1:0] fwd_x_q, fwd_z_q, u_x_q, u_z_q;
  logic signed [W-1:0]    delta_x_q, delta_z_q;
  logic signed [W-1:0]    sin_w, cos_w, delta_x_d, delta_z_d;

  function automatic logic signed [BITS-1:0] lut_fx(input logic [6:0] k);
    logic [BITS-1:0] raw;
    raw = BITS'(QuarterLut[k]);
    return signed'((raw << LutUp) >> LutDn);
  endfunction

  function automatic logic signed [BITS-1:0] sin_fx(input logic [7:0] a);
    logic [6:0] idx;
    idx = a[6] ? 7'd64 - {1'b0, a[5:0]} : {1'b0, a[5:0]};
    return a[7] ? -lut_fx(idx) : lut_fx(idx);
  endfunction

  function automatic logic signed [W-1:0] pick(input logic pos, input logic neg,
                                               input logic signed [W-1:0] val);
    if (pos && !neg) return val;
    if (neg && !pos) return -val;
    return '0;
  endfunction

  function automatic logic signed [BITS-1:0] step_ori(input logic signed [BITS-1:0] cur,
                                                      input logic signed [W-1:0] delta);
    logic signed [W-1:0] sum;
    sum = W'(cur) + delta;
    if (sum > MaxW) sum = MaxW;
    else if (sum < MinW) sum = MinW;
`ifdef CAMERA_BOUNDS_EN
    if (sum > BoundW) sum = BoundW;
    else if (sum < -BoundW) sum = -BoundW;
`endif
    return BITS'(sum);
  endfunction

  // Direction d = (-s, 0, -c), right r = (c, 0, -s); delta = (f*d + t*r) * SPEED.
  always_comb begin
    sin_w     = W'(sin_q);
    cos_w     = W'(cos_q);
    delta_x_d = SpeedW * (pick(fwd_q, back_q, -sin_w) + pick(right_q, left_q, cos_w));
    delta_z_d = SpeedW * (pick(fwd_q, back_q, -cos_w) + pick(right_q, left_q, -sin_w));
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q          <= StIdle;
      {fwd_q, back_q, left_q, right_q, yaw_l_q, yaw_r_q} <= '0;
      yaw_q            <= '0;
      sin_q            <= '0;
      cos_q            <= OneFx;
      fwd_x_q          <= '0;
      fwd_z_q          <= FwdZ0Fx;
      u_x_q            <= OneFx;
      u_z_q            <= '0;
      delta_x_q        <= '0;
      delta_z_q        <= '0;
      camera_ori_x     <= '0;
      camera_ori_y     <= '0;
      camera_ori_z     <= OriZ0Fx;
      camera_u_x       <= OneFx;
      camera_u_y       <= '0;
      camera_u_z       <= '0;
      camera_v_x       <= '0;
      camera_v_y       <= OneFx;
      camera_v_z       <= '0;
      camera_forward_x <= '0;
      camera_forward_y <= '0;
      camera_forward_z <= FwdZ0Fx;
      yaw_out          <= '0;
      busy_out         <= 1'b0;
      update_out       <= 1'b0;
    end else begin
      update_out <= 1'b0;
      case (state_q)
        StIdle: begin
          if (frame_tick_in) begin
            fwd_q    <= btn_fwd_in;
            back_q   <= btn_back_in;
            left_q   <= btn_left_in;
            right_q  <= btn_right_in;
            yaw_l_q  <= btn_yaw_l_in;
            yaw_r_q  <= btn_yaw_r_in;
            busy_out <= 1'b1;
            state_q  <= StYaw;
          end
        end
        StYaw: begin
          if (yaw_l_q && !yaw_r_q) yaw_q <= yaw_q + 8'd1;
          else if (yaw_r_q && !yaw_l_q) yaw_q <= yaw_q - 8'd1;
          state_q <= StTrig;
        end
        StTrig: begin
          sin_q   <= sin_fx(yaw_q);
          cos_q   <= sin_fx(yaw_q + 8'd64);
          state_q <= StScale;
        end
        StScale: begin
          fwd_x_q   <= -(sin_q * FocalB);
          fwd_z_q   <= -(cos_q * FocalB);
          u_x_q     <= cos_q;
          u_z_q     <= -sin_q;
          delta_x_q <= delta_x_d;
          delta_z_q <= delta_z_d;
          state_q   <= StCommit;
        end
        StCommit: begin
          camera_ori_x     <= step_ori(camera_ori_x, delta_x_q);
          camera_ori_z     <= step_ori(camera_ori_z, delta_z_q);
          camera_u_x       <= u_x_q;
          camera_u_z       <= u_z_q;
          camera_forward_x <= fwd_x_q;
          camera_forward_z <= fwd_z_q;
          yaw_out          <= yaw_q;
          update_out       <= 1'b1;
          busy_out         <= 1'b0;
          state_q          <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_camera_controller.sv
// Self-checking bench for camera_controller: directed steps plus random ticks against a
// trigonometric pose model.
module tb_camera_controller;

  localparam int BITS = 32, FRAC = 16, FOCAL = 150, SPEED = 2, ORI_Z0 = 150, BOUND = 1000;
  localparam longint One = longint'(1) << FRAC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, tick = 1'b0;
  logic b_fwd = 0, b_back = 0, b_left = 0, b_right = 0, b_yl = 0, b_yr = 0;
  logic signed [BITS-1:0] ori_x, ori_y, ori_z, u_x, u_y, u_z, v_x, v_y, v_z;
  logic signed [BITS-1:0] fw_x, fw_y, fw_z;
  logic [7:0] yaw;
  logic busy, upd;

  camera_controller #(
    .BITS(BITS), .FRAC(FRAC), .FOCAL(FOCAL), .SPEED(SPEED), .ORI_Z0(ORI_Z0), .BOUND(BOUND)
  ) dut (
    .clk_in(clk), .rst_in(rst), .frame_tick_in(tick),
    .btn_fwd_in(b_fwd), .btn_back_in(b_back), .btn_left_in(b_left), .btn_right_in(b_right),
    .btn_yaw_l_in(b_yl), .btn_yaw_r_in(b_yr),
    .camera_ori_x(ori_x), .camera_ori_y(ori_y), .camera_ori_z(ori_z),
    .camera_u_x(u_x), .camera_u_y(u_y), .camera_u_z(u_z),
    .camera_v_x(v_x), .camera_v_y(v_y), .camera_v_z(v_z),
    .camera_forward_x(fw_x), .camera_forward_y(fw_y), .camera_forward_z(fw_z),
    .yaw_out(yaw), .busy_out(busy), .update_out(upd)
  );

  int total = 0, bad = 0;
  int m_yaw;
  longint m_ori [3];

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint ref_sin(input int a);
    real x;
    x = $sin(real'(a) * 6.283185307179586 / 256.0) * real'(One);
    if (x >= 0.0) return longint'($rtoi(x + 0.5));
    return -longint'($rtoi(-x + 0.5));
  endfunction

  function automatic longint sat(input longint val);
    longint r;
    r = val;
    if (r > 64'sd2147483647) r = 64'sd2147483647;
    if (r < -64'sd2147483648) r = -64'sd2147483648;
`ifdef CAMERA_BOUNDS_EN
    if (r > longint'(BOUND) * One) r = longint'(BOUND) * One;
    if (r < -longint'(BOUND) * One) r = -longint'(BOUND) * One;
`endif
    return r;
  endfunction

  task automatic model_reset();
    m_yaw = 0;
    m_ori[0] = 0;
    m_ori[1] = 0;
    m_ori[2] = longint'(ORI_Z0) * One;
  endtask

  // btn = {fwd, back, left, right, yaw_l, yaw_r}
  task automatic model_tick(input logic [5:0] btn);
    longint s, c, f, t;
    if (btn[1] && !btn[0]) m_yaw = (m_yaw + 1) % 256;
    else if (btn[0] && !btn[1]) m_yaw = (m_yaw + 255) % 256;
    s = ref_sin(m_yaw);
    c = ref_sin(m_yaw + 64);
    f = longint'(btn[5]) - longint'(btn[4]);
    t = longint'(btn[2]) - longint'(btn[3]);
    m_ori[0] = sat(m_ori[0] + (f * -s + t * c) * SPEED);
    m_ori[2] = sat(m_ori[2] + (f * -c + t * -s) * SPEED);
  endtask

  task automatic check_pose(input string p);
    longint s, c;
    s = ref_sin(m_yaw);
    c = ref_sin(m_yaw + 64);
    chk({p, ".ori_x"}, ori_x, m_ori[0]);
    chk({p, ".ori_y"}, ori_y, m_ori[1]);
    chk({p, ".ori_z"}, ori_z, m_ori[2]);
    chk({p, ".u_x"}, u_x, c);
    chk({p, ".u_y"}, u_y, 0);
    chk({p, ".u_z"}, u_z, -s);
    chk({p, ".v_x"}, v_x, 0);
    chk({p, ".v_y"}, v_y, One);
    chk({p, ".v_z"}, v_z, 0);
    chk({p, ".fw_x"}, fw_x, -s * FOCAL);
    chk({p, ".fw_y"}, fw_y, 0);
    chk({p, ".fw_z"}, fw_z, -c * FOCAL);
    chk({p, ".yaw"}, {56'd0, yaw}, m_yaw);
  endtask

  task automatic do_tick(input string p, input logic [5:0] btn, input bit extra);
    logic [5:0] busy_h, upd_h;
    @(negedge clk);
    {b_fwd, b_back, b_left, b_right, b_yl, b_yr} = btn;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      busy_h[k] = busy;
      upd_h[k]  = upd;
      if (extra && k == 1) tick = 1'b1;
      if (extra && k == 2) tick = 1'b0;
    end
    {b_fwd, b_back, b_left, b_right, b_yl, b_yr} = '0;
    model_tick(btn);
    chk({p, ".busy_window"}, {58'd0, busy_h}, 64'd15);
    chk({p, ".update_window"}, {58'd0, upd_h}, 64'd16);
    check_pose(p);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_pose("reset");
    chk("reset.busy", {63'd0, busy}, 0);
    chk("reset.update", {63'd0, upd}, 0);
    chk("reset.ori_z_abs", ori_z, 9830400);

    do_tick("fwd", 6'b100000, 1'b0);
    chk("fwd.ori_z_abs", ori_z, 9699328);

    for (int i = 0; i < 64; i++) do_tick("yaw_l", 6'b000010, 1'b0);
    chk("yaw64.yaw", {56'd0, yaw}, 64);
    chk("yaw64.u_z", u_z, -65536);
    chk("yaw64.fw_x", fw_x, -9830400);
    for (int i = 0; i < 192; i++) do_tick("yaw_l2", 6'b000010, 1'b0);
    chk("yaw256.yaw", {56'd0, yaw}, 0);
    chk("yaw256.u_x", u_x, 65536);
    chk("yaw256.fw_z", fw_z, -9830400);

    do_tick("yaw_r", 6'b000001, 1'b0);
    chk("yaw_r.wrap", {56'd0, yaw}, 255);
    do_tick("yaw_both", 6'b000011, 1'b0);
    chk("yaw_both.hold", {56'd0, yaw}, 255);
    do_tick("fwd_back", 6'b110000, 1'b0);
    do_tick("extra_tick", 6'b001000, 1'b1);

    for (int i = 0; i < 40; i++) do_tick("rand", 6'($urandom_range(0, 63)), 1'b0);

    // reset during SCALE
    @(negedge clk);
    b_fwd = 1'b1;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    chk("rst_scale.busy", {63'd0, busy}, 0);
    chk("rst_scale.update", {63'd0, upd}, 0);
    check_pose("rst_scale");
    rst = 1'b0;
    b_fwd = 1'b0;
    @(negedge clk);
    chk("rst_scale.update_after", {63'd0, upd}, 0);

`ifdef CAMERA_BOUNDS_EN
    for (int i = 0; i < 500; i++) do_tick("bound", 6'b010000, 1'b0);
    chk("bound.ori_z_abs", ori_z, 65536000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
